// File: rtl/systolic_mm_engine.sv
// Weight-stationary ROWS x COLS systolic matrix-vector engine with load/compute/drain sequencing.
// Defining SYSTOLIC_MM_RELU_EN clamps negative output columns to zero.
module systolic_mm_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_vec,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [COLS*DATA_W-1:0]  w_data,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [ROWS*DATA_W-1:0]  a_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [COLS*ACC_W-1:0]   o_data,
    output logic                    o_last,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int L  = ROWS + COLS - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // state_q is the observable controller state for external checkers.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] vec_cnt_q;
    logic [RW-1:0]    w_cnt_q;
    logic             done_q;

    // Every stream transfers one beat on a rising edge where valid && ready; a producer holds
    // valid and data stable until accepted, and ready never depends combinationally on valid.
    logic adv;
    logic w_fire;
    logic a_fire;
    logic o_fire;
    logic last_vec;

    assign adv      = !o_valid || o_ready;
    assign w_ready  = (state_q == LOAD_W);
    assign a_ready  = (state_q == COMPUTE) && adv;
    assign w_fire   = w_valid && w_ready;
    assign a_fire   = a_valid && a_ready;
    assign o_fire   = o_valid && o_ready;
    assign last_vec = (vec_cnt_q == (num_q - CNT_W'(1)));
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !done_q) state_d = LOAD_W;
            end
            LOAD_W: begin
                if (w_fire && (w_cnt_q == RW'(ROWS - 1)))
                    state_d = (num_q == '0) ? DRAIN : COMPUTE;
            end
            COMPUTE: begin
                if (a_fire && last_vec) state_d = DRAIN;
            end
            DRAIN: begin
                if ((num_q == '0) || (o_fire && o_last)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            num_q     <= '0;
            vec_cnt_q <= '0;
            w_cnt_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DRAIN) && (state_d == IDLE);
            if (state_q == IDLE && start && !done_q) begin
                num_q     <= num_vec;
                vec_cnt_q <= '0;
                w_cnt_q   <= '0;
            end else begin
                if (w_fire) w_cnt_q <= w_cnt_q + RW'(1);
                if (a_fire) vec_cnt_q <= vec_cnt_q + CNT_W'(1);
            end
        end
    end

    // act[r][c] is the activation presented to PE(r,c); psum[r][c] is its registered partial sum.
    logic signed [DATA_W-1:0] act  [ROWS][COLS];
    logic signed [ACC_W-1:0]  psum [ROWS][COLS];
    logic signed [ACC_W-1:0]  col_out [COLS];

    genvar r, c;
    generate
        for (r = 0; r < ROWS; r++) begin : g_skew
            logic signed [DATA_W-1:0] a_in;
            assign a_in = a_fire ? a_data[r*DATA_W +: DATA_W] : '0;
            if (r == 0) begin : g_direct
                assign act[0][0] = a_in;
            end else begin : g_delay
                logic signed [DATA_W-1:0] sk [r];
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int i = 0; i < r; i++) sk[i] <= '0;
                    end else if (adv) begin
                        sk[0] <= a_in;
                        for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
                    end
                end
                assign act[r][0] = sk[r-1];
            end
        end

        for (r = 0; r < ROWS; r++) begin : g_row
            for (c = 0; c < COLS; c++) begin : g_pe
                logic signed [DATA_W-1:0]   w_q;
                logic signed [ACC_W-1:0]    psum_q;
                logic signed [ACC_W-1:0]    psum_in;
                logic signed [2*DATA_W-1:0] prod;

                assign prod = act[r][c] * w_q;
                if (r == 0) begin : g_top
                    assign psum_in = '0;
                end else begin : g_inner
                    assign psum_in = psum[r-1][c];
                end

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        w_q    <= '0;
                        psum_q <= '0;
                    end else begin
                        if (w_fire && (w_cnt_q == RW'(r))) w_q <= w_data[c*DATA_W +: DATA_W];
                        if (adv) psum_q <= psum_in + ACC_W'(prod);
                    end
                end
                assign psum[r][c] = psum_q;

                // Activation hop to the right neighbour; the last column has no consumer.
                if (c < COLS - 1) begin : g_pass
                    logic signed [DATA_W-1:0] act_q;
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset)   act_q <= '0;
                        else if (adv) act_q <= act[r][c];
                    end
                    assign act[r][c+1] = act_q;
                end
            end
        end

        for (c = 0; c < COLS; c++) begin : g_deskew
            localparam int D = COLS - 1 - c;
            if (D == 0) begin : g_none
                assign col_out[c] = psum[ROWS-1][c];
            end else begin : g_delay
                logic signed [ACC_W-1:0] dq [D];
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int i = 0; i < D; i++) dq[i] <= '0;
                    end else if (adv) begin
                        dq[0] <= psum[ROWS-1][c];
                        for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
                    end
                end
                assign col_out[c] = dq[D-1];
            end
        end
    endgenerate

    logic [COLS*ACC_W-1:0] res_packed;

    always_comb begin
        res_packed = '0;
        for (int i = 0; i < COLS; i++) begin
`ifdef SYSTOLIC_MM_RELU_EN
            res_packed[i*ACC_W +: ACC_W] = col_out[i][ACC_W-1] ? '0 : col_out[i];
`else
            res_packed[i*ACC_W +: ACC_W] = col_out[i];
`endif
        end
    end

    // Valid/last tags travel alongside the wavefront so the output register knows which slots are real.
    logic [L-1:0] tag_v;
    logic [L-1:0] tag_l;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
            tag_l <= '0;
        end else if (adv) begin
            tag_v[0] <= a_fire;
            tag_l[0] <= a_fire && last_vec;
            for (int i = 1; i < L; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else if (adv) begin
            o_valid <= tag_v[L-1];
            o_last  <= tag_v[L-1] && tag_l[L-1];
            if (tag_v[L-1]) o_data <= res_packed;
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine: directed jobs plus randomized jobs against a dot-product model.
module tb_systolic_mm_engine;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CNT_W  = 16;
    localparam int OW     = COLS * ACC_W;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [CNT_W-1:0]       num_vec;
    logic                   w_valid;
    logic                   w_ready;
    logic [COLS*DATA_W-1:0] w_data;
    logic                   a_valid;
    logic                   a_ready;
    logic [ROWS*DATA_W-1:0] a_data;
    logic                   o_valid;
    logic                   o_ready;
    logic [OW-1:0]          o_data;
    logic                   o_last;
    logic                   busy;
    logic                   done;

    systolic_mm_engine #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
        .busy(busy), .done(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int wm [ROWS][COLS];
    int am [64][ROWS];
    logic [OW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: y[c] = sum_r a[r]*W[r][c], wrapped to ACC_W bits
    function automatic logic [OW-1:0] ref_mv(input int v);
        logic [OW-1:0] res;
        longint s;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) s += longint'(am[v][r]) * longint'(wm[r][c]);
`ifdef SYSTOLIC_MM_RELU_EN
            if (s < 0) s = 0;
`endif
            res[c*ACC_W +: ACC_W] = ACC_W'(s);
        end
        return res;
    endfunction

    function automatic logic [COLS*DATA_W-1:0] pack_w(input int k);
        logic [COLS*DATA_W-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*DATA_W +: DATA_W] = DATA_W'(wm[k][c]);
        return v;
    endfunction

    function automatic logic [ROWS*DATA_W-1:0] pack_a(input int k);
        logic [ROWS*DATA_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*DATA_W +: DATA_W] = DATA_W'(am[k][r]);
        return v;
    endfunction

    function automatic int rnd_s16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic rand_weights();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = rnd_s16();
    endtask

    task automatic rand_vectors(input int n);
        for (int i = 0; i < n; i++)
            for (int r = 0; r < ROWS; r++) am[i][r] = rnd_s16();
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_w_ready"}, w_ready, 0);
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_o_valid"}, o_valid, 0);
        check({tag, "_o_last"},  o_last,  0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_o_data"},  o_data,  '0);
    endtask

    // driver: one job. mode 0 = always ready, 1 = 5-cycle stall window, 2 = random o_ready
    task automatic run_job(input int num, input int mode, input int gap_pct,
                           input bit glitch, input int abort_after);
        int cyc, w_idx, a_idx, n_out, n_last, lat;
        int acc_cyc [$];
        bit fin, prev_hold, prev_last;
        logic [OW-1:0] exp_v, prev_data;
        cyc = 0; w_idx = 0; a_idx = 0; n_out = 0; n_last = 0;
        fin = 0; prev_hold = 0; prev_last = 0; prev_data = '0;
        exp_q.delete();
        @(negedge clk);
        start = 1'b1;
        num_vec = CNT_W'(num);
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            if (abort_after >= 0 && a_idx == abort_after) begin
                a_valid = 1'b0;
                w_valid = 1'b0;
                reset = 1'b0;
                #1;
                check_all_clear("abort");
                repeat (2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                #1;
                check_all_clear("post_abort");
                return;
            end
            start = (glitch && cyc == 1);
            num_vec = (cyc == 1) ? CNT_W'(num + 5) : CNT_W'($urandom);
            w_valid = (w_idx < ROWS);
            w_data  = pack_w((w_idx < ROWS) ? w_idx : 0);
            a_valid = (a_idx < num) && (int'($urandom_range(1, 100)) > gap_pct);
            a_data  = pack_a((a_idx < num) ? a_idx : 0);
            case (mode)
                0:       o_ready = 1'b1;
                1:       o_ready = !(cyc >= 13 && cyc < 18);
                default: o_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (prev_hold) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, prev_data);
                check("hold_last", o_last, prev_last);
            end
            if (o_valid && !o_ready) check("stall_a_ready", a_ready, 0);
            if (w_valid && w_ready) w_idx++;
            if (a_valid && a_ready) begin
                exp_q.push_back(ref_mv(a_idx));
                acc_cyc.push_back(cyc);
                a_idx++;
            end
            if (o_valid && o_ready) begin
                check("out_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    lat = cyc - acc_cyc.pop_front();
                    check("result", o_data, exp_v);
                    check("o_last", o_last, (n_out == num - 1));
                    if (mode == 0) check("latency", lat, ROWS + COLS);
                end
                n_out++;
                if (o_last) n_last++;
            end
            prev_hold = o_valid && !o_ready;
            prev_data = o_data;
            prev_last = o_last;
            if (done) begin
                check("busy_at_done", busy, 0);
                fin = 1;
            end
            cyc++;
        end
        start = 1'b0;
        a_valid = 1'b0;
        w_valid = 1'b0;
        o_ready = 1'b1;
        check("job_done_seen", fin, 1);
        check("result_count", n_out, num);
        check("last_count", n_last, (num > 0) ? 1 : 0);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_vec = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; o_ready = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_clear("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("idle_busy0", busy, 0);
        check("idle_w_ready0", w_ready, 0);
        check("idle_a_ready0", a_ready, 0);

        // identity weights, single vector
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = (r == c) ? 1 : 0;
        for (int r = 0; r < ROWS; r++) am[0][r] = r + 1;
        run_job(1, 0, 0, 0, -1);

        // signed arithmetic
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = 3;
        for (int r = 0; r < ROWS; r++) am[0][r] = -1;
        am[1][0] = 2; am[1][1] = 0; am[1][2] = 0; am[1][3] = -5;
        run_job(2, 0, 0, 0, -1);

        // backpressure mid-stream
        rand_weights();
        rand_vectors(6);
        run_job(6, 1, 0, 0, -1);

        // empty job with a start glitch during weight load
        rand_weights();
        run_job(0, 0, 0, 1, -1);

        // abort after two accepted vectors, then a clean job
        rand_weights();
        rand_vectors(4);
        run_job(4, 0, 0, 0, 2);
        rand_weights();
        rand_vectors(1);
        run_job(1, 0, 0, 0, -1);

        // randomized jobs with input gaps and random output backpressure
        for (int j = 0; j < 4; j++) begin
            rand_weights();
            rand_vectors(12);
            run_job(int'($urandom_range(6, 12)), 2, 25, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
